// File: rtl/shift_seq_pkg.sv
// Shared types for the load-then-shift sequencer: downstream mode-select encoding,
// FSM states and the counter width.
package shift_seq_pkg;

    localparam int unsigned CntWidth = 8;

    typedef enum logic [1:0] {
        SelLoad = 2'b00,
        SelSh0  = 2'b01,
        SelSh3  = 2'b10,
        SelHold = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StFin
    } state_e;

    function automatic sel_e shift_sel(logic dir);
        return dir ? SelSh3 : SelSh0;
    endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Control/status bundle between a sequencer client (master) and shift_seq (slave).
interface shift_seq_if;
    import shift_seq_pkg::*;

    logic                start;
    logic [CntWidth-1:0] count;
    logic                dir;
    logic                fill;
    logic                abort;
    logic [1:0]          sel;
    logic                s0;
    logic                s3;
    logic                busy;
    logic                done;
    logic [CntWidth-1:0] remain;

    modport master (
        output start, count, dir, fill, abort,
        input  sel, s0, s3, busy, done, remain
    );

    modport slave (
        input  start, count, dir, fill, abort,
        output sel, s0, s3, busy, done, remain
    );

endinterface

// File: rtl/shift_seq_cnt.sv
// Loadable 8-bit down-counter that saturates at zero; "one" is registered so the
// FSM can leave SHIFT on the final decrement without a comparator in its path.
module shift_seq_cnt
    import shift_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                load,
    input  logic [CntWidth-1:0] load_val,
    input  logic                dec,
    output logic [CntWidth-1:0] value,
    output logic                one,
    output logic                zero
);

    logic [CntWidth-1:0] cnt_q;
    logic                one_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
            one_q <= 1'b0;
        end else if (load) begin
            cnt_q <= load_val;
            one_q <= (load_val == CntWidth'(1));
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntWidth'(1);
            one_q <= (cnt_q == CntWidth'(2));
        end
    end

    assign value = cnt_q;
    assign one   = one_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/shift_seq.sv
// Load-then-shift sequencer driving the mode select and serial inputs of a
// universal shift-register chain; all outputs are registered decodes of the state.
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    shift_seq_if.slave   bus
);

    state_e state_q, state_d;
    logic   dir_q, dir_d;
    logic   fill_q, fill_d;
    sel_e   sel_q, sel_d;
    logic   s0_q, s0_d;
    logic   s3_q, s3_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_clr;
    logic [CntWidth-1:0] cnt_value;
    logic                cnt_one;
    logic                cnt_zero;

    shift_seq_cnt u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (bus.count),
        .dec      (cnt_dec),
        .value    (cnt_value),
        .one      (cnt_one),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StLoad;
                    cnt_load = 1'b1;
                end
            end
            StLoad:  state_d = cnt_zero ? StFin : StShift;
            StShift: begin
                cnt_dec = 1'b1;
                if (cnt_one) state_d = StFin;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort outranks both START and the count-expiry transition.
        if (bus.abort && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
            cnt_dec = 1'b0;
        end
    end

    always_comb begin
        dir_d  = dir_q;
        fill_d = fill_q;
        if ((state_q == StIdle) && bus.start) begin
            dir_d  = bus.dir;
            fill_d = bus.fill;
        end
    end

    // Output decode of the next state, so the registers below present it with the state.
    always_comb begin
        sel_d  = SelHold;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_d)
            StIdle:  sel_d = SelHold;
            StLoad: begin
                sel_d  = SelLoad;
                busy_d = 1'b1;
            end
            StShift: begin
                sel_d  = shift_sel(dir_d);
                busy_d = 1'b1;
            end
            StFin: begin
                sel_d  = SelHold;
                done_d = 1'b1;
            end
            default: sel_d = SelHold;
        endcase
        s0_d = (state_d != StIdle) && fill_d && !dir_d;
        s3_d = (state_d != StIdle) && fill_d && dir_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            sel_q   <= SelHold;
            s0_q    <= 1'b0;
            s3_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
            sel_q   <= sel_d;
            s0_q    <= s0_d;
            s3_q    <= s3_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sel    = sel_q;
    assign bus.s0     = s0_q;
    assign bus.s3     = s3_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.remain = cnt_value;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: a sequence-level model queues the expected output
// tuple for every cycle, and a negedge monitor pops and compares it.
module tb_shift_seq;
    import shift_seq_pkg::*;

    typedef struct packed {
        logic [1:0] sel;
        logic       s0;
        logic       s3;
        logic       busy;
        logic       done;
        logic [7:0] remain;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    obs_t exp_q[$];
    obs_t pend[$];
    bit   model_idle = 1'b1;

    always #5 clk = ~clk;

    shift_seq_if bus ();

    shift_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic obs_t idle_obs();
        obs_t o;
        o.sel    = 2'b11;
        o.s0     = 1'b0;
        o.s3     = 1'b0;
        o.busy   = 1'b0;
        o.done   = 1'b0;
        o.remain = 8'd0;
        return o;
    endfunction

    // Whole accepted sequence: one load cycle, COUNT shift cycles, one finish cycle.
    task automatic plan_sequence(input logic [7:0] cnt, input logic d, input logic f);
        obs_t o;
        o.s0   = f & ~d;
        o.s3   = f & d;
        o.sel  = 2'b00;
        o.busy = 1'b1;
        o.done = 1'b0;
        o.remain = cnt;
        pend.push_back(o);
        for (int i = 0; i < int'(cnt); i++) begin
            o.sel    = d ? 2'b10 : 2'b01;
            o.remain = 8'(int'(cnt) - i);
            pend.push_back(o);
        end
        o.sel    = 2'b11;
        o.busy   = 1'b0;
        o.done   = 1'b1;
        o.remain = 8'd0;
        pend.push_back(o);
    endtask

    task automatic step(input logic st, input logic [7:0] cnt, input logic d, input logic f,
                        input logic ab, input logic rs);
        obs_t e;
        @(negedge clk);
        #1;
        bus.start = st;
        bus.count = cnt;
        bus.dir   = d;
        bus.fill  = f;
        bus.abort = ab;
        reset     = rs;
        if (rs) begin
            pend.delete();
            e = idle_obs();
        end else if (!model_idle && ab) begin
            pend.delete();
            e = idle_obs();
        end else if (pend.size() > 0) begin
            e = pend.pop_front();
        end else if (model_idle && st) begin
            plan_sequence(cnt, d, f);
            e = pend.pop_front();
        end else begin
            e = idle_obs();
        end
        model_idle = !e.busy && !e.done;
        exp_q.push_back(e);
    endtask

    task automatic idle_step();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_out();
        for (int i = 0; i < 300 && !model_idle; i++) idle_step();
        idle_step();
    endtask

    task automatic start_seq(input logic [7:0] cnt, input logic d, input logic f);
        step(1'b1, cnt, d, f, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        obs_t a, e;
        if (exp_q.size() > 0) begin
            a.sel    = bus.sel;
            a.s0     = bus.s0;
            a.s3     = bus.s3;
            a.busy   = bus.busy;
            a.done   = bus.done;
            a.remain = bus.remain;
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got sel=%b s0=%b s3=%b busy=%b done=%b remain=%0d, want sel=%b s0=%b s3=%b busy=%b done=%b remain=%0d",
                         $time, a.sel, a.s0, a.s3, a.busy, a.done, a.remain,
                         e.sel, e.s0, e.s3, e.busy, e.done, e.remain);
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.count = 8'd0;
        bus.dir   = 1'b0;
        bus.fill  = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b1;

        // Reset, with a START that must be discarded.
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        idle_step();

        // Basic three-cycle shift with S0 entry.
        start_seq(8'd3, 1'b0, 1'b1);
        run_out();

        // Zero count: load then straight to finish.
        start_seq(8'd0, 1'b1, 1'b1);
        run_out();

        // S3 entry with a second START during the second shift cycle.
        start_seq(8'd4, 1'b1, 1'b1);
        idle_step();
        idle_step();
        start_seq(8'd7, 1'b0, 1'b1);
        run_out();

        // Abort during the third shift cycle.
        start_seq(8'd5, 1'b0, 1'b1);
        idle_step();
        idle_step();
        idle_step();
        step(1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        run_out();

        // Maximum count.
        start_seq(8'd255, 1'b0, 1'b0);
        run_out();

        // Reset while REMAIN=7, then a normal single-shift sequence.
        start_seq(8'd10, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idle_step();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        start_seq(8'd1, 1'b0, 1'b1);
        run_out();

        // Random traffic, including aborts and resets at arbitrary points.
        for (int n = 0; n < 600; n++) begin
            logic       st, d, f, ab, rs;
            logic [7:0] cnt;
            st  = ($urandom % 4) == 0;
            cnt = (($urandom % 10) == 0) ? 8'($urandom % 256) : 8'($urandom % 10);
            d   = 1'($urandom % 2);
            f   = 1'($urandom % 2);
            ab  = ($urandom % 30) == 0;
            rs  = ($urandom % 60) == 0;
            step(st, cnt, d, f, ab, rs);
        end
        run_out();

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 CLK  input  1  clock; all state changes on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  begin a load-then-shift sequence; sampled only in IDLE.
REQ-005 COUNT  input  8  number of shift cycles, 0..255; captured with START.
REQ-006 DIR  input  1  direction; 0 = shift with S0 entry (SEL=01), 1 = shift with S3 entry (SEL=10); captured with START.
REQ-007 FILL  input  1  serial fill bit; captured with START.
REQ-008 ABORT  input  1  terminate the sequence; DONE is not raised.
REQ-009 SEL  output  2  mode select to the downstream universal shift-register chain: 00 load, 01 shift S0-in, 10 shift S3-in, 11 hold.
REQ-010 S0  output  1  serial input to the chain's bit-0 end.
REQ-011 S3  output  1  serial input to the chain's bit-3 end.
REQ-012 BUSY  output  1  high in LOAD and SHIFT states.
REQ-013 DONE  output  1  one-cycle completion pulse.
REQ-014 REMAIN  output  8  shift cycles still to be issued.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SHIFT and FIN; all outputs SHALL be Moore outputs decoded from registered state.
REQ-016 IDLE: SEL=11, BUSY=0, DONE=0; START=1 SHALL capture COUNT, DIR and FILL and go to LOAD.
REQ-017 LOAD: SEL=00 for exactly one cycle; next state SHALL be SHIFT if the captured count is nonzero, else FIN.
REQ-018 SHIFT: SEL=01 when DIR=0, 10 when DIR=1; each rising edge SHALL decrement REMAIN; the edge at which REMAIN=1 SHALL go to FIN, so SHIFT lasts exactly COUNT cycles.
REQ-019 FIN: SEL=11, DONE=1, BUSY=0 for one cycle, then IDLE.
REQ-020 S0 SHALL equal the captured FILL when DIR=0 and 0 otherwise; S3 SHALL equal the captured FILL when DIR=1 and 0 otherwise; both SHALL be 0 in IDLE.
REQ-021 Latency from the START sample edge to the first SEL=00 cycle SHALL be one cycle; the total sequence SHALL be COUNT+2 cycles, START edge to IDLE.
REQ-022 START in LOAD, SHIFT or FIN SHALL be ignored, with no queueing.
REQ-023 ABORT=1 in any non-IDLE state SHALL force IDLE on the next edge with SEL=11, REMAIN=0 and no DONE pulse; ABORT has priority over START and over the count-expiry transition.
REQ-024 REMAIN SHALL be captured COUNT in LOAD, decrement in SHIFT, and be 0 in FIN and IDLE; it SHALL never wrap below 0.
REQ-025 COUNT=255 SHALL produce exactly 255 shift cycles.

Reset
REQ-026 RESET=1 SHALL, on the next edge, force IDLE, SEL=11, S0=0, S3=0, BUSY=0, DONE=0, REMAIN=0 and clear the captured DIR/FILL, regardless of the current state.
REQ-027 RESET SHALL have priority over ABORT and START; START asserted together with RESET SHALL be discarded.

Structure
REQ-028 The shared package SHALL hold the SEL encoding enum (LOAD=00, SH0=01, SH3=10, HOLD=11) and the FSM state enum.
REQ-029 The count register SHALL be one sub-module, shift_seq_cnt: an 8-bit loadable down-counter with a registered "one" flag and a combinational "zero" flag.
REQ-030 The FSM and the output decode SHALL live in shift_seq; target size 120-250 lines in total.

Verification
REQ-031 Reset, then START with COUNT=3, DIR=0, FILL=1 -> SEL sequence 00,01,01,01,11; S0=1 during SHIFT; DONE high for one cycle; REMAIN 3,3,2,1,0.
REQ-032 START with COUNT=0 -> SEL 00 for one cycle, then the FIN cycle with DONE=1; SEL is never 01 or 10.
REQ-033 START with COUNT=4, DIR=1, FILL=1; second START in the second SHIFT cycle -> SEL=10 for exactly 4 cycles, S3=1, S0=0, second START ignored.
REQ-034 START with COUNT=5; ABORT during the third SHIFT cycle -> IDLE next edge, SEL=11, REMAIN=0, DONE never asserted.
REQ-035 START with COUNT=255, DIR=0, FILL=0 -> 255 SEL=01 cycles, DONE at cycle 257 after the START edge, REMAIN never wraps.
REQ-036 RESET during SHIFT with REMAIN=7 -> next edge all outputs at reset values; a subsequent START with COUNT=1 runs normally.
